// File: rtl/rr_mux_arbiter_8.sv
// rr_mux_arbiter_8: round-robin arbiter for 8 requesters sharing one serial channel.
//
// A winner is picked from IDLE by searching upward from the requester after the last
// winner (ptr). It then owns the channel for up to BURST_MAX beats. Each grant is
// followed by at least one IDLE cycle.
//
// Ports
//   clk     in   sole clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   req     in   [7:0] per-requester request
//   din     in   [7:0] per-requester serial data bit
//   ready   in   downstream accepts the presented beat
//   gnt     out  [7:0] one-hot grant (registered)
//   sel     out  [2:0] binary index of the granted requester (registered)
//   dout    out  din[sel] while dvalid, else 0
//   dvalid  out  a beat is presented on dout
//   last    out  presented beat is the final one allowed by BURST_MAX
module rr_mux_arbiter_8 #(
   parameter int unsigned BURST_MAX = 4  // 1..16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] din,
   input  logic       ready,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       dout,
   output logic       dvalid,
   output logic       last
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StXfer = 1'b1;

   localparam logic [3:0] LastCnt = 4'(BURST_MAX - 1);

   logic [0:0] state_q, state_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] sel_q, sel_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] cnt_q, cnt_d;

   logic       win_found;
   logic [2:0] win_idx;
   logic [2:0] cand;
   logic       beat_done;

   // First set request searching upward from ptr+1, wrapping 7->0. The last
   // candidate examined is ptr itself, so a lone requester can win again.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      for (int i = 1; i <= 8; i++) begin
         cand = ptr_q + 3'(i);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Outputs: state_q is cleared asynchronously, so all three drop during reset.
   always_comb begin
      dvalid = (state_q == StXfer) && req[sel_q];
      dout   = dvalid && din[sel_q];
      last   = dvalid && (cnt_q == LastCnt);
   end

   assign beat_done = dvalid && ready;
   assign gnt       = gnt_q;
   assign sel       = sel_q;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (win_found) begin
               state_d = StXfer;
               gnt_d   = 8'(1) << win_idx;
               sel_d   = win_idx;
               ptr_d   = win_idx;
               cnt_d   = '0;
            end
         end
         StXfer: begin
            if (!req[sel_q]) begin
               // Withdrawal: leave without completing a beat.
               state_d = StIdle;
               gnt_d   = '0;
            end else if (beat_done) begin
               if (last) begin
                  state_d = StIdle;
                  gnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase
   end

   // ptr resets to 7 so requester 0 has first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= 3'd7;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// Testbench for rr_mux_arbiter_8: two instances (BURST_MAX 4 and 1) on shared inputs,
// both checked each cycle against a behavioural model of owner / beats / pointer.
module tb_rr_mux_arbiter_8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] req = '0;
   logic [7:0] din = '0;
   logic       ready = 1'b0;

   logic [1:0][7:0] gnt_v;
   logic [1:0][2:0] sel_v;
   logic [1:0]      dout_v;
   logic [1:0]      dvalid_v;
   logic [1:0]      last_v;

   int burst_len [2] = '{4, 1};
   int m_owner   [2];
   int m_beats   [2];
   int m_ptr     [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter_8 #(.BURST_MAX(4)) u_dut4 (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .din    (din),
      .ready  (ready),
      .gnt    (gnt_v[0]),
      .sel    (sel_v[0]),
      .dout   (dout_v[0]),
      .dvalid (dvalid_v[0]),
      .last   (last_v[0])
   );

   rr_mux_arbiter_8 #(.BURST_MAX(1)) u_dut1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .din    (din),
      .ready  (ready),
      .gnt    (gnt_v[1]),
      .sel    (sel_v[1]),
      .dout   (dout_v[1]),
      .dvalid (dvalid_v[1]),
      .last   (last_v[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_owner[d] = -1;
         m_beats[d] = 0;
         m_ptr[d]   = 7;
      end
   endtask

   task automatic check_outputs();
      for (int d = 0; d < 2; d++) begin
         logic [7:0] eg;
         logic       ev;
         logic       eo;
         logic       el;
         string      sfx;
         sfx = $sformatf("[B%0d]", burst_len[d]);
         eg = '0;
         ev = 1'b0;
         eo = 1'b0;
         el = 1'b0;
         if (m_owner[d] >= 0) begin
            eg = 8'(1) << m_owner[d];
            ev = req[m_owner[d]];
            eo = ev && din[m_owner[d]];
            el = ev && (m_beats[d] == burst_len[d] - 1);
            check({"sel", sfx}, 32'(sel_v[d]), 32'(m_owner[d]));
         end
         check({"gnt", sfx}, 32'(gnt_v[d]), 32'(eg));
         check({"dvalid", sfx}, 32'(dvalid_v[d]), 32'(ev));
         check({"dout", sfx}, 32'(dout_v[d]), 32'(eo));
         check({"last", sfx}, 32'(last_v[d]), 32'(el));
      end
   endtask

   // Advance the model across one rising edge using the current inputs.
   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         if (m_owner[d] < 0) begin
            if (req != 8'h00) begin
               for (int i = 1; i <= 8; i++) begin
                  int k;
                  k = (m_ptr[d] + i) % 8;
                  if (m_owner[d] < 0 && req[k]) begin
                     m_owner[d] = k;
                     m_ptr[d]   = k;
                     m_beats[d] = 0;
                  end
               end
            end
         end else if (!req[m_owner[d]]) begin
            m_owner[d] = -1;
         end else if (ready) begin
            m_beats[d]++;
            if (m_beats[d] == burst_len[d]) m_owner[d] = -1;
         end
      end
   endtask

   // Called just after a rising edge; inputs held until the next one.
   task automatic do_cycle(input logic [7:0] r, input logic rd);
      req   = r;
      ready = rd;
      din   = 8'($urandom);
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         check({tag, "_gnt"}, 32'(gnt_v[d]), 32'h0);
         check({tag, "_dvalid"}, 32'(dvalid_v[d]), 32'h0);
         check({tag, "_dout"}, 32'(dout_v[d]), 32'h0);
         check({tag, "_last"}, 32'(last_v[d]), 32'h0);
      end
   endtask

   // Assert reset between edges, hold it across one edge with requests present,
   // then release just after that edge.
   task automatic do_reset(input logic [7:0] r);
      req   = r;
      din   = 8'hFF;
      ready = 1'b1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      @(posedge clk);
      #1;
      check_reset_outputs("rst_held");
      for (int d = 0; d < 2; d++) check("rst_sel", 32'(sel_v[d]), 32'h0);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [7:0] r;
      #2;
      do_reset(8'h00);

      // Single requester 5, repeated grants.
      for (int i = 0; i < 12; i++) do_cycle(8'h20, 1'b1);

      // Full round robin from reset.
      do_reset(8'hFF);
      for (int i = 0; i < 46; i++) do_cycle(8'hFF, 1'b1);

      // Drain, then backpressure on requester 3 after beat 2.
      for (int i = 0; i < 2; i++) do_cycle(8'h00, 1'b1);
      for (int i = 0; i < 3; i++) do_cycle(8'h08, 1'b1);
      for (int i = 0; i < 5; i++) do_cycle(8'h08, 1'b0);
      for (int i = 0; i < 4; i++) do_cycle(8'h08, 1'b1);

      // Withdrawal by requester 6 after beat 1; 7 and 0 then compete.
      for (int i = 0; i < 2; i++) do_cycle(8'h00, 1'b1);
      for (int i = 0; i < 2; i++) do_cycle(8'h40, 1'b1);
      for (int i = 0; i < 6; i++) do_cycle(8'h81, 1'b1);

      // Reset during beat 3 of a grant to 2, then 8'h84 after release.
      do_reset(8'h00);
      for (int i = 0; i < 3; i++) do_cycle(8'h04, 1'b1);
      do_reset(8'h04);
      for (int i = 0; i < 8; i++) do_cycle(8'h84, 1'b1);

      // Wrap from ptr=7 with 0 and 7 requesting.
      do_reset(8'h00);
      for (int i = 0; i < 12; i++) do_cycle(8'h81, 1'b1);

      // Random traffic: sticky requests, random ready, occasional reset.
      r = 8'h00;
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
         end
         if ($urandom_range(0, 299) == 0) do_reset(r);
         do_cycle(r, $urandom_range(0, 3) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
